// File: rtl/coin_acceptor_if.sv
// -----------------------------------------------------------------------------
// coin_acceptor_if
//   Issue bus between the coin acceptor and the vending machine FSM.
//
//   coin_code  2  00 none, 01 five, 10 ten (one-cycle code per coin)
//   sink_busy  1  vending machine not ready; 1 = hold issuing
//
//   master : coin acceptor (drives coin_code, observes sink_busy)
//   slave  : vending machine (observes coin_code, drives sink_busy)
// -----------------------------------------------------------------------------
interface coin_acceptor_if;
   logic [1:0] coin_code;
   logic       sink_busy;

   modport master (output coin_code, input sink_busy);
   modport slave  (input coin_code, output sink_busy);
endinterface

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//   Front end of the vending machine. Two raw mechanical coin sensors are
//   synchronised, debounced and edge-detected. Valid insertions are queued in
//   a small FIFO and issued one at a time as a one-cycle code on the issue bus,
//   with an enforced idle gap between codes and backpressure from the sink.
//
// Parameters
//   DEBOUNCE_CYCLES  synced cycles a sensor must disagree before its level flips
//   MIN_GAP          cycles of coin_code=00 forced after every issued code
//   FIFO_DEPTH       pending-coin entries (power of two, >= 2)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   sense_5      raw 5-unit sensor (asynchronous, bouncy)
//   sense_10     raw 10-unit sensor (asynchronous, bouncy)
//   enable       0 = reject every new coin
//   bus          issue bus (master): coin_code out, sink_busy in
//   coin_reject  one-cycle pulse per rejected insertion cycle
//   jam          level, both debounced sensors high
//   fifo_count   entries pending
//   credit_total running credit, saturating at 65535 (only with COIN_COUNT_EN)
//
// Optional feature macro: COIN_COUNT_EN
// -----------------------------------------------------------------------------
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MIN_GAP         = 3,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sense_5,
   input  logic                          sense_10,
   input  logic                          enable,
   coin_acceptor_if.master               bus,
   output logic                          coin_reject,
   output logic                          jam,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef COIN_COUNT_EN
   ,
   output logic [15:0]                   credit_total
`endif
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int FCNT_W  = PTR_W + 1;
   localparam int DBC_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int GAP_W   = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;

   localparam logic [DBC_W-1:0]  DB_LAST  = DBC_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);
   // The gap is MIN_GAP zero cycles: ISSUE->GAP edge, MIN_GAP-1 GAP cycles
   // and the final IDLE cycle that performs the next pop.
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((MIN_GAP > 2) ? MIN_GAP - 2 : 0);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

   // Channel index 0 = five, 1 = ten.
   logic [1:0]       sense;
   logic [1:0]       sync1, sync2;
   logic [1:0]       db_lvl, db_lvl_d;
   logic [DBC_W-1:0] db_cnt [2];
   logic [1:0]       sync_fill;
   logic             armed;

   logic [1:0]       ev;
   logic             any_ev, both_ev, fifo_full, reject, push, pop;
   logic [1:0]       push_code;

   logic [1:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;

   state_t           state;
   logic [1:0]       coin_code_r;
   logic [GAP_W-1:0] gap_cnt;

   assign sense = {sense_10, sense_5};

   // ---- synchronise + debounce -------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1    <= '0;
         sync2    <= '0;
         db_lvl   <= '0;
         db_lvl_d <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= sense;
         sync2    <= sync1;
         db_lvl_d <= db_lvl;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != db_lvl[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  db_lvl[i] <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // ---- arming -------------------------------------------------------------
   // The reset-cleared levels do not count as "seen low": arming waits until
   // the synchronisers hold real samples and both sensors read low with low
   // debounced levels. A sensor held high through reset therefore has to be
   // released before it can produce a coin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_fill <= '0;
         armed     <= 1'b0;
      end else begin
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && (db_lvl == 2'b00) && (sync2 == 2'b00))
            armed <= 1'b1;
      end
   end

   // ---- event / accept-reject ----------------------------------------------
   assign ev        = db_lvl & ~db_lvl_d & {2{armed}};
   assign any_ev    = |ev;
   assign both_ev   = &ev;
   // Fullness is the registered count, i.e. before any same-cycle pop.
   assign fifo_full = (fifo_count == FULL_CNT);
   // A coin seen while the other sensor is already high is treated as jammed
   // even before the registered jam flag has caught up.
   assign reject    = any_ev & (~enable | jam | (&db_lvl) | both_ev | fifo_full);
   assign push      = any_ev & ~reject;
   assign push_code = ev[0] ? 2'b01 : 2'b10;
   assign pop       = (state == S_IDLE) && (fifo_count != '0) && !bus.sink_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coin_reject <= 1'b0;
         jam         <= 1'b0;
      end else begin
         coin_reject <= reject;
         jam         <= &db_lvl;
      end
   end

   // ---- FIFO ----------------------------------------------------------------
   // Storage is data only; pointers and count carry all the state.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= push_code;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ---- issue scheduler -----------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         coin_code_r <= 2'b00;
         gap_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  coin_code_r <= fifo_mem[rd_ptr];
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               coin_code_r <= 2'b00;
               gap_cnt     <= '0;
               state       <= (MIN_GAP > 1) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) state <= S_IDLE;
               else                     gap_cnt <= gap_cnt + 1'b1;
            end
            default: begin
               state       <= S_IDLE;
               coin_code_r <= 2'b00;
            end
         endcase
      end
   end

   assign bus.coin_code = coin_code_r;

`ifdef COIN_COUNT_EN
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {12'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Credited on the pop edge so the total moves with the valid code.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_total <= '0;
      end else if (pop) begin
         credit_total <= sat_add16(credit_total,
                                   (fifo_mem[rd_ptr] == 2'b01) ? 5'd5 : 5'd10);
      end
   end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//   Directed bench for coin_acceptor with default parameters. A negedge
//   monitor logs every non-zero coin_code (edge number and value) and every
//   coin_reject cycle; the main sequence compares these logs and the DUT
//   outputs against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sense_5 = 1'b0;
   logic       sense_10 = 1'b0;
   logic       enable = 1'b1;
   logic       coin_reject;
   logic       jam;
   logic [2:0] fifo_count;
`ifdef COIN_COUNT_EN
   logic [15:0] credit_total;
`endif

   coin_acceptor_if bus_if ();

   always #5 clk = ~clk;

   coin_acceptor dut (
      .clk         (clk),
      .rst         (rst),
      .sense_5     (sense_5),
      .sense_10    (sense_10),
      .enable      (enable),
      .bus         (bus_if),
      .coin_reject (coin_reject),
      .jam         (jam),
      .fifo_count  (fifo_count)
`ifdef COIN_COUNT_EN
      ,
      .credit_total(credit_total)
`endif
   );

   // Edge counter: after rising edge k, cyc == k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         pulse_cyc [$];
   logic [1:0] pulse_val [$];
   int         rej_n = 0;

   always @(negedge clk) begin
      if (bus_if.coin_code !== 2'b00) begin
         pulse_cyc.push_back(cyc);
         pulse_val.push_back(bus_if.coin_code);
      end
      if (coin_reject !== 1'b0) rej_n++;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One insertion: sensor high for 'hold' sampled edges, then low for 'rest'.
   task automatic insert(input bit ten, input int hold, input int rest);
      if (ten) sense_10 = 1'b1; else sense_5 = 1'b1;
      tick(hold);
      if (ten) sense_10 = 1'b0; else sense_5 = 1'b0;
      tick(rest);
   endtask

   initial begin
      int base, rbase, e1;
      bus_if.sink_busy = 1'b0;

      // ---- reset state
      tick(3);
      check("rst_code",   bus_if.coin_code, 2'b00);
      check("rst_reject", coin_reject,      1'b0);
      check("rst_jam",    jam,              1'b0);
      check("rst_count",  fifo_count,       3'd0);
`ifdef COIN_COUNT_EN
      check("rst_credit", credit_total, 16'd0);
`endif
      rst = 1'b1;
      tick(6);

      // ---- single 5-coin, exact latency
      base  = pulse_cyc.size();
      rbase = rej_n;
      sense_5 = 1'b1;
      e1 = cyc + 1;
      tick(7);                               // after edge 7: pushed, not yet popped
      check("t1_count_push", fifo_count, 3'd1);
      tick(1);                               // after edge 8: code valid
      check("t1_code_valid", bus_if.coin_code, 2'b01);
      check("t1_count_pop",  fifo_count, 3'd0);
`ifdef COIN_COUNT_EN
      check("t1_credit", credit_total, 16'd5);
`endif
      tick(1);                               // after edge 9: back to idle code
      check("t1_code_clear", bus_if.coin_code, 2'b00);
      tick(3);                               // 12 sampled-high edges in total
      sense_5 = 1'b0;
      tick(12);
      check("t1_npulse",  pulse_cyc.size() - base, 1);
      check("t1_edge",    pulse_cyc[base], e1 + 7);
      check("t1_val",     pulse_val[base], 2'b01);
      check("t1_reject",  rej_n - rbase, 0);
      check("t1_count",   fifo_count, 3'd0);

      // ---- glitch then bounce on the 10 sensor
      base = pulse_cyc.size();
      sense_10 = 1'b1; tick(2);
      sense_10 = 1'b0; tick(10);
      check("t2_glitch_npulse", pulse_cyc.size() - base, 0);
      check("t2_glitch_count",  fifo_count, 3'd0);
      sense_10 = 1'b1; tick(1);
      sense_10 = 1'b0; tick(1);
      sense_10 = 1'b1; tick(1);
      sense_10 = 1'b0; tick(1);
      sense_10 = 1'b1; tick(12);
      sense_10 = 1'b0; tick(12);
      check("t2_npulse", pulse_cyc.size() - base, 1);
      check("t2_val",    pulse_val[base], 2'b10);
`ifdef COIN_COUNT_EN
      check("t2_credit", credit_total, 16'd15);
`endif

      // ---- backpressure: fill FIFO, reject on full, drain with spacing
      base  = pulse_cyc.size();
      rbase = rej_n;
      bus_if.sink_busy = 1'b1;
      for (int i = 0; i < 4; i++) insert(1'b1, 8, 10);
      check("t3_count_full", fifo_count, 3'd4);
      check("t3_no_reject",  rej_n - rbase, 0);
      insert(1'b1, 8, 10);
      check("t3_reject_full", rej_n - rbase, 1);
      check("t3_count_held",  fifo_count, 3'd4);
      check("t3_busy_npulse", pulse_cyc.size() - base, 0);
      bus_if.sink_busy = 1'b0;
      tick(25);
      check("t3_npulse", pulse_cyc.size() - base, 4);
      if (pulse_cyc.size() - base == 4) begin
         for (int i = 0; i < 4; i++)
            check($sformatf("t3_val%0d", i), pulse_val[base + i], 2'b10);
         for (int i = 1; i < 4; i++)
            check($sformatf("t3_spacing%0d", i), pulse_cyc[base + i] - pulse_cyc[base + i - 1], 4);
      end
      check("t3_count_drained", fifo_count, 3'd0);
`ifdef COIN_COUNT_EN
      check("t3_credit", credit_total, 16'd55);
`endif

      // ---- enable low rejects
      base  = pulse_cyc.size();
      rbase = rej_n;
      enable = 1'b0;
      insert(1'b0, 8, 10);
      enable = 1'b1;
      check("t4_en_reject", rej_n - rbase, 1);
      check("t4_en_npulse", pulse_cyc.size() - base, 0);
      check("t4_en_count",  fifo_count, 3'd0);

      // ---- simultaneous insertion: single reject, jam
      base  = pulse_cyc.size();
      rbase = rej_n;
      sense_5 = 1'b1; sense_10 = 1'b1;
      tick(10);
      check("t5_jam_high",  jam, 1'b1);
      check("t5_reject",    rej_n - rbase, 1);
      check("t5_count",     fifo_count, 3'd0);
      sense_5 = 1'b0; sense_10 = 1'b0;
      tick(10);
      check("t5_jam_low",   jam, 1'b0);
      check("t5_npulse",    pulse_cyc.size() - base, 0);
      insert(1'b0, 8, 12);
      check("t5_after_npulse", pulse_cyc.size() - base, 1);
      if (pulse_cyc.size() > base)
         check("t5_after_val", pulse_val[base], 2'b01);
      check("t5_after_reject", rej_n - rbase, 1);

      // ---- mid-operation reset with a sensor held high through it
      bus_if.sink_busy = 1'b1;
      insert(1'b1, 8, 10);
      insert(1'b1, 8, 10);
      check("t6_count_pre", fifo_count, 3'd2);
      base = pulse_cyc.size();
      sense_5 = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      check("t6_rst_count", fifo_count, 3'd0);
      check("t6_rst_code",  bus_if.coin_code, 2'b00);
      check("t6_rst_jam",   jam, 1'b0);
      rst = 1'b1;
      bus_if.sink_busy = 1'b0;
      tick(20);
      check("t6_held_npulse", pulse_cyc.size() - base, 0);
      check("t6_held_count",  fifo_count, 3'd0);
      sense_5 = 1'b0;
      tick(12);
      insert(1'b0, 8, 12);
      check("t6_reinsert_npulse", pulse_cyc.size() - base, 1);
      if (pulse_cyc.size() > base)
         check("t6_reinsert_val", pulse_val[base], 2'b01);
`ifdef COIN_COUNT_EN
      check("t6_credit", credit_total, 16'd5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
